// File: rtl/fifo_rd_pkg.sv
// Shared constants, FSM encoding and keep-mask helper for the FIFO read-side packer.
package fifo_rd_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_BYTES = 8;

    typedef enum logic [1:0] {
        RUN,
        FLUSH_WAIT,
        FLUSH_EMIT
    } state_e;

    // Low `cnt` bits set; any count of MAX_BYTES or more yields all ones.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [3:0] cnt);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(cnt)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_lanes.sv
// Lane register and byte count: writes each arriving byte into lane `cnt`.
// Also exposes the word with the arriving byte already merged in.
module fifo_byte_packer
    import fifo_rd_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int CW    = $clog2(BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_vld_i,
    input  logic [BYTE_W-1:0]       byte_i,
    input  logic                    take_i,
    output logic [CW-1:0]           cnt_o,
    output logic [BYTES*BYTE_W-1:0] word_o
);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BYTES*BYTE_W-1:0] data_q, data_d;

    always_comb begin
        word_o = data_q;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_vld_i && cnt_q == CW'(i)) word_o[i*BYTE_W +: BYTE_W] = byte_i;
        end
    end

    // Clearing on take keeps every lane above `cnt` at zero for partial words.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (take_i) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (byte_vld_i) begin
            cnt_d  = cnt_q + CW'(1);
            data_d = word_o;
        end
    end

    // NOTE: the lane register is reset, unlike a RAM array, because a partial word relies on its unused lanes reading zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// FIFO read-side engine: pop rule, flush FSM and output register.
// Packs BYTES little-endian bytes per valid/ready word.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int DW    = BYTE_W * BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [BYTE_W-1:0] fifo_dout,
    output logic              fifo_rd,
    input  logic              flush,
    output logic              flush_done,
    output logic              busy,
    output logic [DW-1:0]     m_data,
    output logic [BYTES-1:0]  m_keep,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int          CW   = $clog2(BYTES + 1);
    localparam logic [CW:0] FULL = (CW+1)'(BYTES);

    state_e           state_q, state_d;
    logic             rd_q;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    word;
    logic [CW:0]      fill;
    logic             out_free, full_take, flush_take, take;
    logic [DW-1:0]    data_q, data_d;
    logic [BYTES-1:0] keep_q, keep_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;

    fifo_byte_packer #(
        .BYTES (BYTES),
        .CW    (CW)
    ) u_lanes (
        .clk        (clk),
        .rst        (rst),
        .byte_vld_i (rd_q),
        .byte_i     (fifo_dout),
        .take_i     (take),
        .cnt_o      (cnt),
        .word_o     (word)
    );

    // Held bytes plus the byte in flight; never exceeds BYTES.
    assign fill       = {1'b0, cnt} + {{CW{1'b0}}, rd_q};
    assign out_free   = !valid_q || m_ready;
    assign full_take  = out_free && ((rd_q && fill == FULL) ||
                                     (state_q == RUN && {1'b0, cnt} == FULL));
    assign flush_take = out_free && state_q == FLUSH_EMIT;
    assign take       = full_take || flush_take;

    // NOTE: defaults are assigned first in every always_comb so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        fifo_rd = 1'b0;
        if (!rst && !fifo_empty && state_q == RUN) begin
            fifo_rd = (fill < FULL) || (fill == FULL && rd_q && out_free);
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush) state_d = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                if (!rd_q) begin
                    if (cnt != '0) begin
                        state_d = FLUSH_EMIT;
                    end else begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH_EMIT: begin
                if (out_free) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (take) begin
            valid_d = 1'b1;
            data_d  = word;
            keep_d  = flush_take ? BYTES'(keep_mask(4'(cnt))) : '1;
            last_d  = flush_take;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= fifo_rd;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign m_valid    = valid_q;
    assign m_data     = data_q;
    assign m_keep     = keep_q;
    assign m_last     = last_q;
    assign flush_done = done_q;
    assign busy       = rd_q || (cnt != '0) || valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (BYTES=4) with a 1-cycle-latency FIFO model.
// Output handshakes and pop activity are recorded on the falling edge.
module tb_fifo_rd_packer;

    localparam int BYTES = 4;
    localparam int DW    = 8 * BYTES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty;
    logic [7:0]       fifo_dout = 8'h00;
    logic             fifo_rd;
    logic             flush = 1'b0;
    logic             flush_done;
    logic             busy;
    logic [DW-1:0]    m_data;
    logic [BYTES-1:0] m_keep;
    logic             m_last;
    logic             m_valid;
    logic             m_ready = 1'b1;

    always #5 clk = ~clk;

    fifo_rd_packer #(.BYTES(BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    // FIFO model: written by the stimulus, popped on the rising edge.
    logic [7:0] fmem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_dout <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Monitor
    logic             mon_clr = 1'b1;
    int               cyc = 0;
    int               nwords = 0;
    int               rd_count = 0;
    int               streak = 0;
    int               max_streak = 0;
    int               first_rd = -1;
    int               first_vld = -1;
    int               underflow = 0;
    logic [DW-1:0]    w_data [0:15];
    logic [BYTES-1:0] w_keep [0:15];
    logic             w_last [0:15];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd && fifo_empty) underflow <= underflow + 1;
        if (mon_clr) begin
            nwords     <= 0;
            rd_count   <= 0;
            streak     <= 0;
            max_streak <= 0;
            first_rd   <= -1;
            first_vld  <= -1;
        end else begin
            if (fifo_rd) begin
                rd_count <= rd_count + 1;
                streak   <= streak + 1;
                if (streak + 1 > max_streak) max_streak <= streak + 1;
                if (first_rd < 0) first_rd <= cyc;
            end else begin
                streak <= 0;
            end
            if (m_valid && first_vld < 0) first_vld <= cyc;
            if (m_valid && m_ready) begin
                if (nwords < 16) begin
                    w_data[nwords] <= m_data;
                    w_keep[nwords] <= m_keep;
                    w_last[nwords] <= m_last;
                end
                nwords <= nwords + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr] = b;
        wr_ptr       = wr_ptr + 8'd1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step(1);
        mon_clr = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (nwords < n && k < budget) begin
            step(1);
            k++;
        end
        check("words_arrived", 64'(nwords), 64'(n));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_m_valid",    64'(m_valid),    64'd0);
        check("rst_m_data",     64'(m_data),     64'd0);
        check("rst_m_keep",     64'(m_keep),     64'd0);
        check("rst_m_last",     64'(m_last),     64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_fifo_rd",    64'(fifo_rd),    64'd0);
        rst = 1'b0;
        step(2);

        // One full word
        clear_mon();
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        wait_words(1, 20);
        step(3);
        check("t1_nwords",  64'(nwords),     64'd1);
        check("t1_data",    64'(w_data[0]),  64'hD4C3B2A1);
        check("t1_keep",    64'(w_keep[0]),  64'hF);
        check("t1_last",    64'(w_last[0]),  64'd0);
        check("t1_rd_cnt",  64'(rd_count),   64'd4);
        check("t1_latency", 64'(first_vld - first_rd), 64'd5);

        // 16 bytes streamed back to back
        clear_mon();
        for (int i = 1; i <= 16; i++) push(8'(i));
        wait_words(4, 60);
        step(2);
        check("t2_rd_cnt", 64'(rd_count),   64'd16);
        check("t2_streak", 64'(max_streak), 64'd16);
        check("t2_word0",  64'(w_data[0]),  64'h04030201);
        check("t2_word1",  64'(w_data[1]),  64'h08070605);
        check("t2_word3",  64'(w_data[3]),  64'h100F0E0D);
        check("t2_keep3",  64'(w_keep[3]),  64'hF);

        // Backpressure: 12 bytes queued, only two words' worth may be popped
        clear_mon();
        m_ready = 1'b0;
        for (int i = 8'h11; i <= 8'h1C; i++) push(8'(i));
        step(8);
        check("t3_hold_early", 64'(m_data),     64'h14131211);
        step(12);
        check("t3_rd_stalled", 64'(rd_count),   64'd8);
        check("t3_valid",      64'(m_valid),    64'd1);
        check("t3_hold_late",  64'(m_data),     64'h14131211);
        check("t3_no_accept",  64'(nwords),     64'd0);
        check("t3_busy",       64'(busy),       64'd1);
        check("t3_fifo_left",  64'(fifo_empty), 64'd0);
        m_ready = 1'b1;
        wait_words(3, 40);
        step(3);
        check("t3_word0",  64'(w_data[0]), 64'h14131211);
        check("t3_word1",  64'(w_data[1]), 64'h18171615);
        check("t3_word2",  64'(w_data[2]), 64'h1C1B1A19);
        check("t3_rd_all", 64'(rd_count),  64'd12);

        // Flush of a 3-byte partial word
        clear_mon();
        push(8'hA1); push(8'hB2); push(8'hC3);
        step(8);
        check("t4_no_word", 64'(m_valid), 64'd0);
        check("t4_busy",    64'(busy),    64'd1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t4_done_c1", 64'(flush_done), 64'd0);
        step(1);
        check("t4_done_c2", 64'(flush_done), 64'd0);
        step(1);
        check("t4_done",    64'(flush_done), 64'd1);
        check("t4_valid",   64'(m_valid),    64'd1);
        check("t4_last",    64'(m_last),     64'd1);
        check("t4_keep",    64'(m_keep),     64'h7);
        check("t4_data",    64'(m_data),     64'h00C3B2A1);
        step(1);
        check("t4_done_off",  64'(flush_done), 64'd0);
        check("t4_valid_off", 64'(m_valid),    64'd0);

        // Flush while idle
        clear_mon();
        step(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t5_done_c1", 64'(flush_done), 64'd0);
        step(1);
        check("t5_done",    64'(flush_done), 64'd1);
        check("t5_valid",   64'(m_valid),    64'd0);
        step(1);
        check("t5_done_off", 64'(flush_done), 64'd0);
        step(3);
        check("t5_nwords",  64'(nwords), 64'd0);

        // Reset mid-word, then a clean word from new bytes only
        clear_mon();
        push(8'h55); push(8'h66);
        step(6);
        check("t6_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        push(8'h77); push(8'h88); push(8'h99); push(8'hAA);
        step(1);
        check("t6_valid",   64'(m_valid),    64'd0);
        check("t6_data",    64'(m_data),     64'd0);
        check("t6_keep",    64'(m_keep),     64'd0);
        check("t6_last",    64'(m_last),     64'd0);
        check("t6_done",    64'(flush_done), 64'd0);
        check("t6_busy",    64'(busy),       64'd0);
        check("t6_fifo_rd", 64'(fifo_rd),    64'd0);
        rst = 1'b0;
        wait_words(1, 20);
        step(2);
        check("t6_word", 64'(w_data[0]), 64'hAA998877);
        check("t6_wkeep", 64'(w_keep[0]), 64'hF);
        check("t6_nwords", 64'(nwords),  64'd1);

        check("no_underflow", 64'(underflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
